gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//   Registered up/down binary counter that produces its Gray-coded value in the
//   same cycle as the binary count. It is the sequential stage that feeds Gray
//   codes to downstream consumers, such as pointer synchronisers and encoders.
//   It also checks that every count step changes exactly one Gray bit.
// PARAMETERS
//   WIDTH     4   counter / code width in bits (>= 2)
//   SATURATE  0   0: wrap around at limits; 1: hold at limits
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous clear to 0 (highest priority)
//   load       in   1      synchronous load of load_val
//   load_val   in   WIDTH  binary value for load
//   en         in   1      count enable (one step per cycle)
//   up         in   1      1: increment, 0: decrement
//   binary     out  WIDTH  registered binary count
//   gray       out  WIDTH  registered Gray code, equal to binary ^ (binary >> 1)
//   wrap       out  1      1-cycle pulse: the count step crossed a limit
//   at_limit   out  1      registered: binary == max (up=1) or 0 (up=0) at last edge
//   step_err   out  1      sticky: a count step changed != 1 gray bit
// BEHAVIOUR
//   - Reset (rst_n=0, async, any time): binary=0, gray=0, wrap=0, at_limit=0,
//     step_err=0. Release is sampled on the next rising clk.
//   - Priority per edge: clear > load > en. With none asserted, all registers hold
//     and wrap=0.
//   - Latency: inputs sampled at edge N appear on outputs right after edge N.
//     binary and gray always update on the same edge.
//   - gray register is loaded from next_binary ^ (next_binary >> 1). It is never
//     derived from the old gray value.
//   - Arithmetic is modulo 2^WIDTH. max = 2^WIDTH-1.
//   - SATURATE=0:
//       en & up & binary==max gives binary=0 and wrap=1.
//       en & !up & binary==0 gives binary=max and wrap=1.
//   - SATURATE=1: a step at the limit holds the value, wrap stays 0, and at_limit=1.
//   - at_limit is computed from next_binary and the up value sampled in the same cycle.
//   - wrap is a registered pulse, high only for the cycle after a wrapping step.
//     It is never set by clear or load.
//   - step_err checker:
//       Runs only on an en step (not clear/load) where the value changed.
//       Sets if popcount(gray_next ^ gray) != 1.
//       Cleared only by rst_n, never by clear or load.
//   - up may toggle any cycle. Direction takes effect on that edge's step.
//   - Simultaneous clear and load: clear wins, binary=0.
//   - Simultaneous load and en: load wins, no step, wrap=0.
// TESTING
//   1 Reset: rst_n=0 -> all outputs 0. Release, en=0 for 3 cycles -> binary holds 0.
//   2 Count up: en=1, up=1 for 16 cycles from 0 ->
//       gray = 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0
//       wrap=1 only on the 15->0 step; step_err stays 0.
//   3 Count down: en=1, up=0 from 0 -> binary=F, gray=8, wrap=1.
//       Next cycle -> binary=E, gray=9, wrap=0.
//   4 Load/priority:
//       load=1, load_val=A, en=1 -> binary=A, gray=F, wrap=0.
//       Next cycle clear=1, load=1 -> binary=0, gray=0.
//   5 Saturate (SATURATE=1): load F, en=1, up=1 for 3 cycles ->
//       binary stays F, gray=8, at_limit=1, wrap=0.
//   6 Async reset mid-count: at binary=7, drive rst_n=0 between edges ->
//       outputs go to 0 immediately, without waiting for a clock edge.
//       After release the count resumes from 0.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code twin and a one-bit-change checker.
// One-cycle latency from sampled inputs to outputs; no backpressure (every edge is accepted).
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_limit,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;
  logic             step_err_q, step_err_d;
  logic             at_edge;
  logic             step;

  always_comb begin
    binary_d = binary_q;
    wrap_d   = 1'b0;
    step     = 1'b0;
    at_edge  = up ? (binary_q == MAX) : (binary_q == ZERO);

    if (clear) begin
      binary_d = ZERO;
    end else if (load) begin
      binary_d = load_val;
    end else if (en) begin
      step = 1'b1;
      if (at_edge) begin
        if (!SATURATE) begin
          binary_d = up ? ZERO : MAX;
          wrap_d   = 1'b1;
        end
      end else begin
        binary_d = up ? (binary_q + ONE) : (binary_q - ONE);
      end
    end

    // Gray is always re-encoded from the new binary, never stepped from the old code.
    gray_d     = binary_d ^ (binary_d >> 1);
    at_limit_d = up ? (binary_d == MAX) : (binary_d == ZERO);
    step_err_d = step_err_q |
                 (step && (binary_d != binary_q) && ($countones(gray_d ^ gray_q) != 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binary_q   <= ZERO;
      gray_q     <= ZERO;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      binary_q   <= binary_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
      step_err_q <= step_err_d;
    end
  end

  assign binary   = binary_q;
  assign gray     = gray_q;
  assign wrap     = wrap_q;
  assign at_limit = at_limit_q;
  assign step_err = step_err_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: wrapping and saturating instances driven in lockstep
// and compared against an integer-arithmetic reference model.
module tb_gray_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, clear, load, en, up;
  logic [W-1:0] load_val;
  logic [W-1:0] b0, g0, b1, g1;
  logic         w0, l0, e0, w1, l1, e1;

  int errors = 0;
  int checks = 0;

  int m_bin  [2];
  bit m_wrap [2];
  bit m_lim  [2];
  bit m_err  [2];
  int n_bin  [2];
  bit n_wrap [2];
  bit n_lim  [2];
  bit n_err  [2];

  logic [3:0] gtab [16];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .binary(b0), .gray(g0), .wrap(w0), .at_limit(l0), .step_err(e0)
  );

  gray_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .binary(b1), .gray(g1), .wrap(w1), .at_limit(l1), .step_err(e1)
  );

  function automatic int gc(int v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      m_bin[s] = 0; m_wrap[s] = 0; m_lim[s] = 0; m_err[s] = 0;
    end
  endtask

  task automatic predict();
    for (int s = 0; s < 2; s++) begin
      int b;
      int nb;
      bit w;
      b  = m_bin[s];
      nb = b;
      w  = 0;
      if (clear) nb = 0;
      else if (load) nb = int'(load_val);
      else if (en) begin
        if (up) begin
          nb = b + 1;
          if (nb > MAX) begin nb = (s == 1) ? MAX : 0; w = (s == 0); end
        end else begin
          nb = b - 1;
          if (nb < 0) begin nb = (s == 1) ? 0 : MAX; w = (s == 0); end
        end
      end
      n_bin[s]  = nb;
      n_wrap[s] = w;
      n_lim[s]  = up ? (nb == MAX) : (nb == 0);
      n_err[s]  = m_err[s] |
                  (!clear && !load && en && nb != b && $countones(gc(nb) ^ gc(b)) != 1);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".bin0"},  32'(b0), 32'(m_bin[0]));
    chk({tag, ".gray0"}, 32'(g0), 32'(gc(m_bin[0])));
    chk({tag, ".wrap0"}, 32'(w0), 32'(m_wrap[0]));
    chk({tag, ".lim0"},  32'(l0), 32'(m_lim[0]));
    chk({tag, ".err0"},  32'(e0), 32'(m_err[0]));
    chk({tag, ".bin1"},  32'(b1), 32'(m_bin[1]));
    chk({tag, ".gray1"}, 32'(g1), 32'(gc(m_bin[1])));
    chk({tag, ".wrap1"}, 32'(w1), 32'(m_wrap[1]));
    chk({tag, ".lim1"},  32'(l1), 32'(m_lim[1]));
    chk({tag, ".err1"},  32'(e1), 32'(m_err[1]));
  endtask

  // Inputs are applied 1 time unit after an edge; outputs checked 1 unit after the next edge.
  task automatic cycle(string tag, bit c, bit l, int lv, bit e, bit u);
    clear = c; load = l; load_val = W'(lv); en = e; up = u;
    predict();
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      m_bin[s] = n_bin[s]; m_wrap[s] = n_wrap[s]; m_lim[s] = n_lim[s]; m_err[s] = n_err[s];
    end
    check_all(tag);
  endtask

  initial begin
    gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst_n = 1'b0; clear = 0; load = 0; load_val = '0; en = 0; up = 1;
    reset_model();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) cycle("idle", 0, 0, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      cycle("up", 0, 0, 0, 1, 1);
      chk("gray_seq", 32'(g0), 32'(gtab[i]));
      chk("wrap_seq", 32'(w0), (i == 15) ? 32'd1 : 32'd0);
    end

    cycle("down_wrap", 0, 0, 0, 1, 0);
    chk("down_wrap.gray", 32'(g0), 32'h8);
    chk("down_wrap.wrap", 32'(w0), 32'd1);
    cycle("down_next", 0, 0, 0, 1, 0);
    chk("down_next.gray", 32'(g0), 32'h9);

    cycle("load_en", 0, 1, 10, 1, 1);
    chk("load_en.gray", 32'(g0), 32'hF);
    cycle("clear_load", 1, 1, 5, 0, 1);
    chk("clear_load.bin", 32'(b0), 32'h0);

    cycle("load_f", 0, 1, 15, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle("sat", 0, 0, 0, 1, 1);
      chk("sat.bin", 32'(b1), 32'hF);
      chk("sat.lim", 32'(l1), 32'd1);
      chk("sat.wrap", 32'(w1), 32'd0);
    end

    cycle("load7", 0, 1, 7, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    cycle("resume", 0, 0, 0, 1, 1);
    chk("resume.bin", 32'(b0), 32'd1);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, MAX)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
